out_byte_serializer: RTL and testbench

- Transmit end of the Top byte-serial output interface: serializes the 128-bit AES cipher block and then the 256-bit HMAC-SHA3 tag onto o_data, one byte per clock.
- Sits between the AES/HMAC cores and the Top output pins (o_data, o_valid).
- Each result is framed as one contiguous o_valid burst: 16 bytes for the cipher, then 32 bytes for the MAC, separated by at least GAP_CYCLES cycles with o_valid low, so the host sees two distinct rising edges.

---
 rtl/top_pkg.sv | 15 +
 rtl/out_byte_serializer.sv | 131 +++++++++++++
 tb/tb_out_byte_serializer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/top_pkg.sv
// Constants and FSM state type shared by the Top byte-serial output path and its bench.
package top_pkg;

  localparam int unsigned CIPHER_BYTES = 16;
  localparam int unsigned MAC_BYTES    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSendC,
    StGap,
    StSendM,
    StDone
  } state_e;

endpackage

// File: rtl/out_byte_serializer.sv
// Sends the 128-bit cipher block and then the 256-bit MAC tag out one byte per clock,
// little-endian, as two separate o_valid bursts with a guaranteed low gap in between.
module out_byte_serializer
  import top_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] i_cipher,
  input  logic         i_cipher_valid,
  output logic         o_cipher_ready,
  input  logic [255:0] i_mac,
  input  logic         i_mac_valid,
  output logic         o_mac_ready,
  output logic [7:0]   o_data,
  output logic         o_valid,
  output logic         o_done
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [5:0] CLast = 6'(CIPHER_BYTES - 1);
  localparam logic [5:0] MLast = 6'(MAC_BYTES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [127:0]    c_buf_q;
  logic [255:0]    m_buf_q;
  logic            c_pend_q, c_pend_d;
  logic            m_pend_q, m_pend_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            c_acc, m_acc;
  logic [127:0]    c_sh;
  logic [255:0]    m_sh;

  assign o_cipher_ready = !c_pend_q && (state_q != StSendC);
  assign o_mac_ready    = !m_pend_q && (state_q != StSendM);
  assign c_acc          = i_cipher_valid && o_cipher_ready;
  assign m_acc          = i_mac_valid && o_mac_ready;

  // Holding registers only load on acceptance; their reset value is never observed.
  always_ff @(posedge clk) begin
    if (c_acc) c_buf_q <= i_cipher;
    if (m_acc) m_buf_q <= i_mac;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      c_pend_q <= 1'b0;
      m_pend_q <= 1'b0;
      cnt_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      c_pend_q <= c_pend_d;
      m_pend_q <= m_pend_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    c_pend_d = c_pend_q | c_acc;
    m_pend_d = m_pend_q | m_acc;
    case (state_q)
      StIdle: begin
        // A pending MAC alone never starts output: the cipher always goes first.
        if (c_pend_q) begin
          state_d = StSendC;
          cnt_d   = '0;
        end
      end
      StSendC: begin
        if (cnt_q == CLast) begin
          c_pend_d = 1'b0;
          state_d  = StGap;
          gap_d    = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StGap: begin
        // The counter saturates, so a late MAC starts on the very next edge.
        if (gap_q != GapLast) begin
          gap_d = gap_q + 1'b1;
        end else if (m_pend_q) begin
          state_d = StSendM;
          cnt_d   = '0;
        end
      end
      StSendM: begin
        if (cnt_q == MLast) begin
          m_pend_d = 1'b0;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign c_sh = c_buf_q >> {cnt_q, 3'b000};
  assign m_sh = m_buf_q >> {cnt_q, 3'b000};

  // All outputs decode registered state only, so they move on clock edges (or reset).
  always_comb begin
    o_data  = 8'h00;
    o_valid = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      StSendC: begin
        o_valid = 1'b1;
        o_data  = c_sh[7:0];
      end
      StSendM: begin
        o_valid = 1'b1;
        o_data  = m_sh[7:0];
      end
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_out_byte_serializer.sv
// Directed bench for out_byte_serializer with a byte-level scoreboard on the output bursts.
module tb_out_byte_serializer;
  import top_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] i_cipher = '0;
  logic         i_cipher_valid = 1'b0;
  logic         o_cipher_ready;
  logic [255:0] i_mac = '0;
  logic         i_mac_valid = 1'b0;
  logic         o_mac_ready;
  logic [7:0]   o_data;
  logic         o_valid;
  logic         o_done;

  always #5 clk = ~clk;

  out_byte_serializer #(.GAP_CYCLES(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cipher       (i_cipher),
    .i_cipher_valid (i_cipher_valid),
    .o_cipher_ready (o_cipher_ready),
    .i_mac          (i_mac),
    .i_mac_valid    (i_mac_valid),
    .o_mac_ready    (o_mac_ready),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .o_done         (o_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: expected event did not occur", tag);
  endtask

  // Scoreboard state: accepted loads are queued, bursts alternate cipher then MAC.
  logic [127:0] c_q[$];
  logic [255:0] m_q[$];
  logic [255:0] cur;
  int  cyc, acc_c, acc_m, acc_c_cyc, acc_m_cyc;
  int  n_c, n_m, n_done, idx, low_run, last_gap, c_start_cyc, m_start_cyc, end_cyc;
  bit  prev_acc_c, prev_acc_m, in_burst, cur_mac, next_is_mac;

  task automatic monitor();
    cyc++;
    if (!rst_n) begin
      c_q.delete();
      m_q.delete();
      in_burst    = 1'b0;
      next_is_mac = 1'b0;
      low_run     = 0;
      prev_acc_c  = 1'b0;
      prev_acc_m  = 1'b0;
      return;
    end
    if (prev_acc_c) chk("c_ready_after_accept", o_cipher_ready, 0);
    if (prev_acc_m) chk("m_ready_after_accept", o_mac_ready, 0);
    prev_acc_c = i_cipher_valid && o_cipher_ready;
    prev_acc_m = i_mac_valid && o_mac_ready;
    if (prev_acc_c) begin
      c_q.push_back(i_cipher);
      acc_c++;
      acc_c_cyc = cyc;
    end
    if (prev_acc_m) begin
      m_q.push_back(i_mac);
      acc_m++;
      acc_m_cyc = cyc;
    end
    chk("done_pulse", o_done, in_burst && cur_mac && !o_valid);
    if (o_done) n_done++;
    if (o_valid) begin
      if (!in_burst) begin
        in_burst = 1'b1;
        cur_mac  = next_is_mac;
        idx      = 0;
        last_gap = low_run;
        cur      = '0;
        if (cur_mac) begin
          n_m++;
          m_start_cyc = cyc;
          if (m_q.size() == 0) fail("mac_burst_without_load");
          else cur = m_q.pop_front();
        end else begin
          n_c++;
          c_start_cyc = cyc;
          if (c_q.size() == 0) fail("cipher_burst_without_load");
          else cur = {128'b0, c_q.pop_front()};
        end
      end
      chk(cur_mac ? "mac_byte" : "cipher_byte", o_data, cur[8*idx +: 8]);
      idx++;
      low_run = 0;
    end else begin
      chk("idle_data_zero", o_data, 0);
      if (in_burst) begin
        chk(cur_mac ? "mac_len" : "cipher_len", idx, cur_mac ? MAC_BYTES : CIPHER_BYTES);
        in_burst    = 1'b0;
        next_is_mac = !cur_mac;
        end_cyc     = cyc;
      end
      low_run++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor();
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Presents the selected loads and drops each valid once its acceptance is seen.
  task automatic drive(input bit dc, input bit dm, input logic [127:0] c, input logic [255:0] m);
    int a0c, a0m, k;
    a0c = acc_c;
    a0m = acc_m;
    k   = 0;
    i_cipher = c;
    i_mac    = m;
    i_cipher_valid = dc;
    i_mac_valid    = dm;
    while ((i_cipher_valid || i_mac_valid) && k < 200) begin
      @(posedge clk);
      #2;
      k++;
      if (acc_c != a0c) i_cipher_valid = 1'b0;
      if (acc_m != a0m) i_mac_valid = 1'b0;
    end
    if (i_cipher_valid || i_mac_valid) begin
      fail("accept_timeout");
      i_cipher_valid = 1'b0;
      i_mac_valid    = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 300) begin
      idle(1);
      k++;
    end
    if (n_done < target) fail("done_timeout");
  endtask

  logic [127:0] c_seq;
  logic [255:0] m_seq;
  int c0, m0, k;

  initial begin
    for (int b = 0; b < 32; b++) begin
      if (b < 16) c_seq[8*b +: 8] = 8'(b);
      m_seq[8*b +: 8] = 8'(b);
    end

    // Reset state
    idle(3);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_done, 0);
    chk("rst_c_ready", o_cipher_ready, 1);
    chk("rst_m_ready", o_mac_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // Cipher and MAC loaded together
    drive(1'b1, 1'b1, c_seq, m_seq);
    wait_done(1);
    chk("t1_latency", c_start_cyc, acc_c_cyc + 2);
    chk("t1_gap", last_gap, 2);
    chk("t1_bursts", {n_c[15:0], n_m[15:0]}, {16'd1, 16'd1});

    // MAC before cipher
    drive(1'b0, 1'b1, '0, rnd256());
    idle(10);
    chk("t2_no_burst", n_c, 1);
    chk("t2_valid_low", o_valid, 0);
    chk("t2_m_ready_low", o_mac_ready, 0);
    drive(1'b1, 1'b0, rnd128(), '0);
    wait_done(2);
    chk("t2_bursts", {n_c[15:0], n_m[15:0]}, {16'd2, 16'd2});

    // Late MAC: extended gap, then MAC with no further gap
    drive(1'b1, 1'b0, rnd128(), '0);
    k = 0;
    while (!(n_c == 3 && !in_burst) && k < 100) begin
      idle(1);
      k++;
    end
    if (!(n_c == 3 && !in_burst)) fail("t3_cipher_timeout");
    idle(20);
    chk("t3_valid_low", o_valid, 0);
    drive(1'b0, 1'b1, '0, rnd256());
    wait_done(3);
    chk("t3_mac_latency", m_start_cyc, acc_m_cyc + 2);
    chk("t3_gap_extended", last_gap >= 20, 1);

    // Back-to-back: second cipher accepted during SEND_M
    drive(1'b1, 1'b1, rnd128(), rnd256());
    k = 0;
    while (!(n_m == 4 && in_burst) && k < 100) begin
      idle(1);
      k++;
    end
    if (!(n_m == 4 && in_burst)) fail("t4_mac_timeout");
    chk("t4_c_ready_in_send_m", o_cipher_ready, 1);
    drive(1'b1, 1'b0, {128{1'b1}}, '0);
    drive(1'b0, 1'b1, '0, rnd256());
    k = 0;
    while (!(n_c == 5 && in_burst) && k < 100) begin
      idle(1);
      k++;
    end
    if (!(n_c == 5 && in_burst)) fail("t4_cipher_timeout");
    chk("t4_restart", c_start_cyc, end_cyc + 2);
    chk("t4_gap", last_gap, 2);
    wait_done(5);

    // Reset during byte 7 of the MAC burst
    drive(1'b1, 1'b1, rnd128(), rnd256());
    k = 0;
    forever begin
      @(negedge clk);
      #1;
      k++;
      if ((in_burst && cur_mac && idx == 8) || k > 200) break;
    end
    if (!(in_burst && cur_mac && idx == 8)) fail("t5_mac_byte7_timeout");
    rst_n = 1'b0;
    #1;
    chk("t5_valid_async", o_valid, 0);
    chk("t5_data_async", o_data, 0);
    @(posedge clk);
    #2;
    idle(2);
    rst_n = 1'b1;
    idle(10);
    chk("t5_c_ready", o_cipher_ready, 1);
    chk("t5_m_ready", o_mac_ready, 1);
    chk("t5_no_done", n_done, 5);
    chk("t5_quiet", o_valid, 0);

    // Held valid: one acceptance per pending slot, repeated 16-byte cipher bursts
    c0 = acc_c;
    m0 = acc_m;
    i_cipher = rnd128();
    i_mac    = rnd256();
    i_cipher_valid = 1'b1;
    i_mac_valid    = 1'b1;
    idle(40);
    i_cipher_valid = 1'b0;
    i_mac_valid    = 1'b0;
    chk("t6_c_accepts", acc_c - c0, 2);
    chk("t6_m_accepts", acc_m - m0, 1);
    idle(150);
    if (acc_c > acc_m) drive(1'b0, 1'b1, '0, rnd256());
    wait_done(acc_m - 1);
    idle(5);
    chk("t6_c_bursts", n_c, acc_c);
    chk("t6_m_bursts", n_m, acc_m);
    chk("t6_dones", n_done, acc_m - 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
